// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencing and single-outstanding instruction fetch for the RV32I core.
// Define PC_MISALIGN_TRAP_EN to trap misaligned redirects to TRAP_VEC instead of truncating them.
//
// state | meaning
// BOOT  | drive RESET_PC into the PC register, no request
// REQ   | fetch request presented at current_pc
// WAIT  | request accepted, waiting for the response beat
// OUT   | instruction held for decode
// DROP  | squashed request outstanding, discard its response
module pc_fetch_ctrl #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] TRAP_VEC   = 32'h4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] current_pc,
   output logic [DATA_WIDTH-1:0] next_pc,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_instr,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  misalign_trap,
   output logic [DATA_WIDTH-1:0] trap_tval
);

   typedef enum logic [2:0] {BOOT, REQ, WAIT, OUT, DROP} state_t;

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   state_t                state, state_d;
   logic                  redir;
   logic                  latch_instr;
   logic [DATA_WIDTH-1:0] redir_target;

   // Redirects arriving while still booting are dropped; the boot PC wins.
   assign redir         = redirect_valid && (state != BOOT);
   assign imem_req_addr = current_pc;
   assign if_pc         = current_pc;

`ifdef PC_MISALIGN_TRAP_EN
   logic misaligned;

   assign misaligned   = (redirect_pc[1:0] != 2'b00);
   assign redir_target = misaligned ? TRAP_VEC : redirect_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_trap <= 1'b0;
         trap_tval     <= '0;
      end else begin
         misalign_trap <= redir && misaligned;
         if (redir && misaligned) begin
            trap_tval <= redirect_pc;
         end
      end
   end
`else
   assign redir_target  = redirect_pc & {{(DATA_WIDTH-2){1'b1}}, 2'b00};
   assign misalign_trap = 1'b0;
   assign trap_tval     = '0;
`endif

   always_comb begin
      state_d        = state;
      next_pc        = current_pc;
      imem_req_valid = 1'b0;
      if_valid       = 1'b0;
      latch_instr    = 1'b0;
      case (state)
         BOOT: begin
            next_pc = RESET_PC;
            state_d = REQ;
         end
         REQ: begin
            imem_req_valid = 1'b1;
            if (redir) begin
               next_pc = redir_target;
               state_d = imem_req_ready ? DROP : REQ;
            end else if (imem_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (redir) begin
               next_pc = redir_target;
               state_d = imem_resp_valid ? REQ : DROP;
            end else if (imem_resp_valid) begin
               latch_instr = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (redir) begin
               next_pc = redir_target;
               state_d = REQ;
            end else begin
               if_valid = 1'b1;
               if (if_ready) begin
                  next_pc = current_pc + PC_STEP;
                  state_d = REQ;
               end
            end
         end
         DROP: begin
            if (redir) begin
               next_pc = redir_target;
            end
            if (imem_resp_valid) begin
               state_d = REQ;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= BOOT;
         if_instr <= '0;
      end else begin
         state <= state_d;
         if (latch_instr) begin
            if_instr <= imem_resp_data;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: external PC register, latency-programmable memory model,
// and a scoreboard monitor checking request, decode and trap handshakes.
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] current_pc;
   logic [31:0] next_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        misalign_trap;
   logic [31:0] trap_tval;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_req[$];
   logic [63:0] exp_if[$];
   logic [31:0] exp_trap[$];

   int          mem_lat;
   bit          poison;
   bit          pend;
   int          pend_cnt;
   logic [31:0] pend_data;

`ifdef PC_MISALIGN_TRAP_EN
   localparam bit TRAP_ON = 1'b1;
`else
   localparam bit TRAP_ON = 1'b0;
`endif

   pc_fetch_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .current_pc      (current_pc),
      .next_pc         (next_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_pc           (if_pc),
      .if_instr        (if_instr),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .misalign_trap   (misalign_trap),
      .trap_tval       (trap_tval)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) current_pc <= next_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return poison ? 32'hDEADBEEF : (addr ^ 32'h0000_0013);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexp(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: unexpected handshake (got event, expected none) at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_if_valid(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (if_valid) return;
         tick();
      end
      chk("wait_if_valid_timeout", {31'd0, if_valid}, 32'd1);
   endtask

   // Memory model: one response beat mem_lat cycles after acceptance.
   initial begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      pend            = 1'b0;
      pend_cnt        = 0;
      pend_data       = '0;
      forever begin
         @(negedge clk);
         imem_resp_valid = 1'b0;
         if (rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               if (pend_cnt <= 1) begin
                  imem_resp_valid = 1'b1;
                  imem_resp_data  = pend_data;
                  pend            = 1'b0;
               end else begin
                  pend_cnt--;
               end
            end
            if (imem_req_valid && imem_req_ready) begin
               pend      = 1'b1;
               pend_cnt  = mem_lat;
               pend_data = mem_word(imem_req_addr);
            end
         end
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (imem_req_valid && imem_req_ready) begin
            if (exp_req.size() == 0) unexp("req");
            else chk("req_addr", imem_req_addr, exp_req.pop_front());
         end
         if (if_valid && if_ready) begin
            if (exp_if.size() == 0) begin
               unexp("if");
            end else begin
               logic [63:0] e;
               e = exp_if.pop_front();
               chk("if_pc", if_pc, e[63:32]);
               chk("if_instr", if_instr, e[31:0]);
            end
         end
         if (misalign_trap) begin
            if (exp_trap.size() == 0) unexp("trap");
            else chk("trap_tval", trap_tval, exp_trap.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] newpc;
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_lat        = 1;
      poison         = 1'b0;

      // reset held three cycles
      tick();
      tick();
      tick();
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_trap_tval", trap_tval, 32'h0);
      chk("rst_misalign_trap", {31'd0, misalign_trap}, 32'd0);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h8);
      exp_if.push_back({32'h0, 32'h0000_0013});
      exp_if.push_back({32'h4, 32'h0000_0017});
      exp_if.push_back({32'h8, 32'h0000_001B});
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      rst            = 1'b0;

      // first cycle after release: BOOT
      chk("boot_next_pc", next_pc, 32'h0);
      chk("boot_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("first_req_addr", imem_req_addr, 32'h0);

      // fetch 0, then stall decode on fetch 4
      wait_if_valid(10);
      tick();
      if_ready = 1'b0;
      wait_if_valid(10);
      for (int i = 0; i < 5; i++) begin
         chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
         chk("stall_next_pc", next_pc, 32'h4);
         chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
         tick();
      end
      if_ready = 1'b1;
      tick();
      chk("after_stall_req_addr", imem_req_addr, 32'h8);
      wait_if_valid(10);

      // redirect in WAIT with a stale response three cycles after acceptance
      mem_lat = 3;
      poison  = 1'b1;
      exp_req.push_back(32'hC);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      #1;
      chk("wait_redir_next_pc", next_pc, 32'h100);
      chk("wait_redir_if_valid", {31'd0, if_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      mem_lat        = 1;
      poison         = 1'b0;
      chk("drop_if_valid", {31'd0, if_valid}, 32'd0);
      exp_req.push_back(32'h100);
      exp_if.push_back({32'h100, 32'h0000_0113});
      tick();
      chk("drop2_if_valid", {31'd0, if_valid}, 32'd0);
      chk("drop2_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      chk("post_drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("post_drop_req_addr", imem_req_addr, 32'h100);
      chk("stale_discarded", if_instr, 32'h0000_001B);
      wait_if_valid(10);

      // misaligned redirect in OUT
      exp_req.push_back(32'h104);
      tick();
      if_ready = 1'b0;
      wait_if_valid(10);
      newpc          = TRAP_ON ? 32'h4 : 32'h100;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      if (TRAP_ON) exp_trap.push_back(32'h102);
      #1;
      chk("out_redir_if_valid", {31'd0, if_valid}, 32'd0);
      chk("misalign_next_pc", next_pc, newpc);
      tick();
      redirect_valid = 1'b0;
      chk("trap_pulse", {31'd0, misalign_trap}, {31'd0, TRAP_ON});
      chk("trap_tval_val", trap_tval, TRAP_ON ? 32'h102 : 32'h0);
      chk("misalign_req_addr", imem_req_addr, newpc);
      exp_req.push_back(newpc);
      exp_if.push_back({newpc, newpc ^ 32'h13});
      if_ready = 1'b1;
      tick();
      chk("trap_pulse_end", {31'd0, misalign_trap}, 32'd0);
      wait_if_valid(10);

      // withdrawn request, then wrap past the top of the address space
      imem_req_ready = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      #1;
      chk("withdraw_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("withdraw_req_addr", imem_req_addr, newpc + 32'h4);
      chk("withdraw_next_pc", next_pc, 32'hFFFF_FFFC);
      tick();
      redirect_valid = 1'b0;
      exp_req.push_back(32'hFFFF_FFFC);
      exp_if.push_back({32'hFFFF_FFFC, 32'hFFFF_FFEF});
      imem_req_ready = 1'b1;
      wait_if_valid(10);
      chk("wrap_next_pc", next_pc, 32'h0);
      tick();
      imem_req_ready = 1'b0;
      chk("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("wrap_req_addr", imem_req_addr, 32'h0);

      tick();
      tick();
      tick();
      chk("req_queue_drained", exp_req.size(), 32'd0);
      chk("if_queue_drained", exp_if.size(), 32'd0);
      chk("trap_queue_drained", exp_trap.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
